operand_entry: RTL and testbench



---
 rtl/calc_pkg.sv | 21 ++
 rtl/operand_entry_digit_accumulator.sv | 60 ++++++
 rtl/operand_entry.sv | 108 ++++++++++
 tb/tb_operand_entry.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator datapath: bus widths, key codes,
// entry FSM encodings and the 11-bit operand format.
package calc_pkg;
    localparam int BUS_W       = 11;
    localparam int VAL_W       = 10;
    localparam int VAL_MAX     = 511;
    localparam int VAL_MIN_MAG = 512;

    localparam logic [3:0] KEY_NEG   = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ACLR  = 4'hD;

    localparam logic [0:0] ST_ENTRY   = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    typedef struct packed {
        logic             ovf;
        logic [VAL_W-1:0] val;
    } operand_t;
endpackage

// File: rtl/operand_entry_digit_accumulator.sv
// Decimal digit accumulator: builds the magnitude x10+d, tracks sign, and converts
// to the 11-bit operand format. OPERAND_ENTRY_SAT_EN saturates out-of-range values.
module digit_accumulator
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dig_en,
    input  logic [3:0] digit,
    input  logic       neg_tgl,
    input  logic       clr,
    output operand_t   value
);
    logic [VAL_W-1:0] mag_q, mag_d;
    logic             neg_q, neg_d;
    logic [1:0]       dcnt_q, dcnt_d;
    logic             ovf;

    always_comb begin
        mag_d  = mag_q;
        neg_d  = neg_q;
        dcnt_d = dcnt_q;
        if (clr) begin
            mag_d  = '0;
            neg_d  = 1'b0;
            dcnt_d = '0;
        end else begin
            // x10 as shift-add; three digits never exceed 999 so 10 bits suffice
            if (dig_en && (int'(dcnt_q) < MAX_DIGITS)) begin
                mag_d  = (mag_q << 3) + (mag_q << 1) + {6'b0, digit};
                dcnt_d = dcnt_q + 2'd1;
            end
            if (neg_tgl) neg_d = ~neg_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q  <= '0;
            neg_q  <= 1'b0;
            dcnt_q <= '0;
        end else begin
            mag_q  <= mag_d;
            neg_q  <= neg_d;
            dcnt_q <= dcnt_d;
        end
    end

    always_comb begin
        ovf       = neg_q ? (mag_q > 10'(VAL_MIN_MAG)) : (mag_q > 10'(VAL_MAX));
        value.ovf = ovf;
        value.val = neg_q ? (~mag_q + 10'd1) : mag_q;
`ifdef OPERAND_ENTRY_SAT_EN
        if (ovf) value.val = neg_q ? 10'h200 : 10'h1FF;
`else
`endif
    end
endmodule

// File: rtl/operand_entry.sv
// Keypad operand entry: collects NUM_OPS signed operands into slot registers and
// presents them downstream over valid/ready. Honours OPERAND_ENTRY_SAT_EN via the accumulator.
module operand_entry
    import calc_pkg::*;
#(
    parameter int NUM_OPS    = 3,
    parameter int MAX_DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    output logic [BUS_W-1:0] entry_val,
    output logic [1:0]       entry_idx,
    output logic [BUS_W-1:0] op_a,
    output logic [BUS_W-1:0] op_b,
    output logic [BUS_W-1:0] op_c,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam logic [1:0] LAST_IDX = 2'(NUM_OPS - 1);

    logic [0:0]     state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    operand_t [2:0] ops_q, ops_d;
    operand_t       entry;
    logic           key_fire, dig_en, neg_tgl, acc_clr;

    assign key_fire = key_valid && (state_q == ST_ENTRY);
    assign dig_en   = key_fire && (key_code <= 4'd9);
    assign neg_tgl  = key_fire && (key_code == KEY_NEG);

    digit_accumulator #(.MAX_DIGITS(MAX_DIGITS)) u_acc (
        .clk     (clk),
        .rst     (rst),
        .dig_en  (dig_en),
        .digit   (key_code),
        .neg_tgl (neg_tgl),
        .clr     (acc_clr),
        .value   (entry)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ops_d   = ops_q;
        acc_clr = 1'b0;
        if (state_q == ST_ENTRY) begin
            if (key_valid) begin
                case (key_code)
                    KEY_ENTER: begin
                        for (int i = 0; i < NUM_OPS; i++)
                            if (idx_q == 2'(i)) ops_d[i] = entry;
                        acc_clr = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = ST_PRESENT;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                    KEY_CLEAR: acc_clr = 1'b1;
                    KEY_ACLR: begin
                        acc_clr = 1'b1;
                        idx_d   = '0;
                        ops_d   = '0;
                    end
                    default: ;
                endcase
            end
        end else if (out_ready) begin
            state_d = ST_ENTRY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ENTRY;
            idx_q   <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ops_q   <= ops_d;
        end
    end

    assign key_ready = (state_q == ST_ENTRY);
    assign out_valid = (state_q == ST_PRESENT);
    assign entry_val = entry;
    assign entry_idx = idx_q;
    assign op_a      = ops_q[0];

    // Slots beyond NUM_OPS are never written, but tie them off explicitly anyway
    generate
        if (NUM_OPS > 1) begin : g_op_b
            assign op_b = ops_q[1];
        end else begin : g_op_b_tie
            assign op_b = '0;
        end
        if (NUM_OPS > 2) begin : g_op_c
            assign op_c = ops_q[2];
        end else begin : g_op_c_tie
            assign op_c = '0;
        end
    endgenerate
endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: directed test-plan steps plus random keys,
// compared against an integer-arithmetic reference model.
module tb_operand_entry;
    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [10:0] entry_val;
    logic [1:0]  entry_idx;
    logic [10:0] op_a, op_b, op_c;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int fails  = 0;

    // reference model state
    int m_mag, m_dcnt, m_idx;
    bit m_neg, m_present;
    logic [10:0] m_ops [3];

    operand_entry dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .entry_val(entry_val), .entry_idx(entry_idx),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] conv(input int mag, input bit neg);
        int v;
        bit ovf;
        logic [9:0] b;
        v   = neg ? -mag : mag;
        ovf = (v > 511) || (v < -512);
        b   = 10'(v);
`ifdef OPERAND_ENTRY_SAT_EN
        if (ovf) b = neg ? 10'h200 : 10'h1FF;
`endif
        return {ovf, b};
    endfunction

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("entry_val", entry_val, conv(m_mag, m_neg));
        chk("entry_idx", 11'(entry_idx), 11'(m_idx));
        chk("op_a", op_a, m_ops[0]);
        chk("op_b", op_b, m_ops[1]);
        chk("op_c", op_c, m_ops[2]);
        chk("out_valid", 11'(out_valid), 11'(m_present));
        chk("key_ready", 11'(key_ready), 11'(!m_present));
    endtask

    task automatic model_reset();
        m_mag = 0; m_neg = 0; m_dcnt = 0; m_idx = 0; m_present = 0;
        for (int i = 0; i < 3; i++) m_ops[i] = '0;
    endtask

    task automatic model_step(input bit kv, input logic [3:0] kc, input bit ordy);
        if (m_present) begin
            if (ordy) m_present = 0;
        end else if (kv) begin
            if (kc <= 4'd9) begin
                if (m_dcnt < 3) begin
                    m_mag = m_mag * 10 + int'(kc);
                    m_dcnt++;
                end
            end else if (kc == 4'hA) begin
                m_neg = !m_neg;
            end else if (kc == 4'hB) begin
                m_ops[m_idx] = conv(m_mag, m_neg);
                m_mag = 0; m_neg = 0; m_dcnt = 0;
                if (m_idx == 2) begin
                    m_idx = 0;
                    m_present = 1;
                end else m_idx++;
            end else if (kc == 4'hC) begin
                m_mag = 0; m_neg = 0; m_dcnt = 0;
            end else if (kc == 4'hD) begin
                model_reset();
            end
        end
    endtask

    // one clock: drive, edge, update model, sample 1 time unit later
    task automatic cyc(input bit kv, input logic [3:0] kc, input bit ordy);
        key_valid = kv;
        key_code  = kc;
        out_ready = ordy;
        @(posedge clk);
        model_step(kv, kc, ordy);
        #1;
        check_all();
    endtask

    task automatic key(input logic [3:0] kc, input bit ordy);
        cyc(1'b1, kc, ordy);
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; out_ready = 1'b0;
        model_reset();
        #12;
        check_all();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1'b0, 4'h0, 1'b0);

        // three operands with out_ready held high
        key(4'd1, 1); key(4'd2, 1); key(4'd3, 1); key(4'hB, 1);
        key(4'd4, 1); key(4'd5, 1); key(4'hB, 1);
        key(4'hA, 1); key(4'd6, 1); key(4'hB, 1);
        chk("tp1_valid", 11'(out_valid), 11'd1);
        chk("tp1_op_a", op_a, 11'h07B);
        chk("tp1_op_b", op_b, 11'h02D);
        chk("tp1_op_c", op_c, 11'h3FA);
        cyc(1'b0, 4'h0, 1'b1);
        chk("tp1_valid_drop", 11'(out_valid), 11'd0);

        // 999 overflows
        key(4'd9, 0); key(4'd9, 0); key(4'd9, 0); key(4'hB, 0);
`ifdef OPERAND_ENTRY_SAT_EN
        chk("ovf999", op_a, 11'h5FF);
`else
        chk("ovf999", op_a, 11'h7E7);
`endif
        chk("ovf999_idx", 11'(entry_idx), 11'd1);

        // range boundaries
        key(4'hA, 0); key(4'd5, 0); key(4'd1, 0); key(4'd2, 0); key(4'hB, 0);
        chk("neg512", op_b, 11'h200);
        key(4'hA, 0); key(4'd5, 0); key(4'd1, 0); key(4'd3, 0); key(4'hB, 0);
        chk("neg513_ovf", 11'(op_c[10]), 11'd1);
        cyc(1'b0, 4'h0, 1'b1);
        key(4'd5, 0); key(4'd1, 0); key(4'd1, 0);
        chk("pos511", entry_val, 11'h1FF);
        key(4'hC, 0);
        key(4'd5, 0); key(4'd1, 0); key(4'd2, 0);
        chk("pos512_ovf", 11'(entry_val[10]), 11'd1);
        key(4'hC, 0);

        // digit limit and clearing
        key(4'd1, 0); key(4'd2, 0); key(4'd3, 0); key(4'd4, 0);
        chk("digit_limit", entry_val, 11'h07B);
        key(4'hC, 0);
        chk("clear_val", entry_val, 11'h000);
        chk("clear_idx", 11'(entry_idx), 11'd0);
        key(4'd7, 0); key(4'hB, 0); key(4'd8, 0); key(4'hB, 0);
        key(4'd3, 0); key(4'hD, 0);
        chk("aclr_idx", 11'(entry_idx), 11'd0);
        chk("aclr_op_a", op_a, 11'h000);
        chk("aclr_op_b", op_b, 11'h000);

        // backpressure: PRESENT held for 10 cycles with keys hammering
        key(4'd1, 0); key(4'hB, 0); key(4'd2, 0); key(4'hB, 0); key(4'd3, 0); key(4'hB, 0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'($urandom_range(0, 13)), 1'b0);
        chk("bp_op_a", op_a, 11'h001);
        chk("bp_valid", 11'(out_valid), 11'd1);
        cyc(1'b0, 4'h0, 1'b1);
        key(4'd7, 0); key(4'hB, 0);
        chk("bp_slot0", op_a, 11'h007);

        // asynchronous reset mid-entry
        key(4'd4, 0); key(4'd2, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        rst = 1'b0;
        key(4'd5, 0); key(4'hB, 0);
        chk("post_rst_slot0", op_a, 11'h005);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [3:0] kc;
            r = int'($urandom_range(0, 99));
            if (r < 60)      kc = 4'($urandom_range(0, 9));
            else if (r < 72) kc = 4'hA;
            else if (r < 88) kc = 4'hB;
            else if (r < 94) kc = 4'hC;
            else if (r < 96) kc = 4'hD;
            else             kc = 4'($urandom_range(14, 15));
            cyc(($urandom_range(0, 3) != 0), kc, ($urandom_range(0, 1) != 0));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
